// File: rtl/serial_frame_collector_if.sv
// Bundle between the sequence detector's serial output and the frame collector.
// The master drives the step enable and serial pair; the slave publishes frame results.
interface serial_frame_collector_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             clkEN;
  logic             SerOutValid;
  logic             SerOut;
  logic [WIDTH-1:0] ParOut;
  logic [3:0]       BitCount;
  logic             Overflow;
  logic             FrameDone;
  logic [3:0]       FrameCount;

  modport master (
    output clkEN, SerOutValid, SerOut,
    input  ParOut, BitCount, Overflow, FrameDone, FrameCount
  );

  modport slave (
    input  clkEN, SerOutValid, SerOut,
    output ParOut, BitCount, Overflow, FrameDone, FrameCount
  );
endinterface

// File: rtl/serial_frame_collector.sv
// Assembles each SerOutValid burst, sampled on clkEN steps, into a parallel word and
// publishes word, bit length, overflow flag and a running frame count on frame end.
module serial_frame_collector #(
  parameter int unsigned WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  serial_frame_collector_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             ov_q, ov_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             take;

  assign take = bus.clkEN & bus.SerOutValid;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    par_d   = par_q;
    bcnt_d  = bcnt_q;
    ovf_d   = ovf_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      // DONE exits exactly like IDLE, so a frame may start in the publish cycle.
      StIdle, StDone: begin
        if (take) begin
          sh_d    = {{(WIDTH-1){1'b0}}, bus.SerOut};
          cnt_d   = 4'd1;
          ov_d    = 1'b0;
          state_d = StCollect;
        end else begin
          state_d = StIdle;
        end
      end
      StCollect: begin
        if (take) begin
          sh_d = {sh_q[WIDTH-2:0], bus.SerOut};
          if (cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
          // cnt_q already holds WIDTH bits, so this one is bit WIDTH+1 or later.
          if (cnt_q >= 4'(WIDTH)) ov_d = 1'b1;
        end else if (bus.clkEN) begin
          state_d = StDone;
          par_d   = sh_q;
          bcnt_d  = cnt_q;
          ovf_d   = ov_q;
          fcnt_d  = fcnt_q + 4'd1;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      par_q   <= '0;
      bcnt_q  <= '0;
      ovf_q   <= 1'b0;
      fcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      par_q   <= par_d;
      bcnt_q  <= bcnt_d;
      ovf_q   <= ovf_d;
      fcnt_q  <= fcnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.ParOut     = par_q;
  assign bus.BitCount   = bcnt_q;
  assign bus.Overflow   = ovf_q;
  assign bus.FrameDone  = done_q;
  assign bus.FrameCount = fcnt_q;

endmodule

// File: tb/tb_serial_frame_collector.sv
// Bench for serial_frame_collector: directed frames plus random traffic, checked every
// cycle against a bit-queue model of the frame rules.
module tb_serial_frame_collector;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;

  serial_frame_collector_if #(.WIDTH(W)) sif ();

  serial_frame_collector #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;
  logic prev_fd = 1'b0;

  // Reference model: bits of the open frame, plus the published values.
  bit           bits_q[$];
  bit           in_frame = 1'b0;
  logic [W-1:0] e_par = '0;
  logic [3:0]   e_bc  = '0;
  logic [3:0]   e_fc  = '0;
  logic         e_ov  = 1'b0;
  logic         e_fd  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic en, input logic v, input logic d, input logic r);
    logic [W-1:0] w;
    if (r) begin
      bits_q.delete();
      in_frame = 1'b0;
      e_par = '0; e_bc = '0; e_fc = '0; e_ov = 1'b0; e_fd = 1'b0;
      return;
    end
    e_fd = 1'b0;
    if (in_frame) begin
      if (en && v) begin
        bits_q.push_back(d);
      end else if (en) begin
        w = '0;
        foreach (bits_q[i]) w = (w << 1) | W'(bits_q[i]);
        e_par = w;
        e_bc  = (bits_q.size() > 15) ? 4'd15 : 4'(bits_q.size());
        e_ov  = (bits_q.size() > W);
        e_fc  = e_fc + 4'd1;
        e_fd  = 1'b1;
        in_frame = 1'b0;
      end
    end else if (en && v) begin
      bits_q.delete();
      bits_q.push_back(d);
      in_frame = 1'b1;
    end
  endtask

  task automatic cycle(input logic en, input logic v, input logic d, input logic r);
    sif.clkEN = en;
    sif.SerOutValid = v;
    sif.SerOut = d;
    rst = r;
    @(posedge clk);
    #1;
    model_step(en, v, d, r);
    chk("FrameDone", 32'(sif.FrameDone), 32'(e_fd));
    chk("ParOut", 32'(sif.ParOut), 32'(e_par));
    chk("BitCount", 32'(sif.BitCount), 32'(e_bc));
    chk("Overflow", 32'(sif.Overflow), 32'(e_ov));
    chk("FrameCount", 32'(sif.FrameCount), 32'(e_fc));
    chk("fd_consec", 32'(prev_fd & sif.FrameDone), 32'd0);
    if (sif.FrameDone === 1'b1) pulses++;
    prev_fd = sif.FrameDone;
  endtask

  // Sends n bits MSB first, with optional gated cycles between steps, then ends the frame.
  task automatic send_frame(input logic [15:0] b, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) repeat ($urandom_range(0, 2)) cycle(1'b0, 1'($urandom), 1'($urandom), 1'b0);
      cycle(1'b1, 1'b1, b[i], 1'b0);
    end
    cycle(1'b1, 1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic reset2();
    repeat (2) cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
  endtask

  initial begin
    logic v_r;
    int   len;

    // Reset with random inputs
    reset2();
    chk("rst_par", 32'(sif.ParOut), 32'd0);
    chk("rst_bc", 32'(sif.BitCount), 32'd0);
    chk("rst_fc", 32'(sif.FrameCount), 32'd0);
    chk("rst_fd", 32'(sif.FrameDone), 32'd0);

    // 8-bit frame
    send_frame(16'h00B2, 8, 1'b0);
    chk("b2_par", 32'(sif.ParOut), 32'hB2);
    chk("b2_bc", 32'(sif.BitCount), 32'd8);
    chk("b2_ov", 32'(sif.Overflow), 32'd0);
    chk("b2_fd", 32'(sif.FrameDone), 32'd1);
    chk("b2_fc", 32'(sif.FrameCount), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Short frame
    send_frame(16'b110, 3, 1'b1);
    chk("short_par", 32'(sif.ParOut), 32'h06);
    chk("short_bc", 32'(sif.BitCount), 32'd3);
    chk("short_ov", 32'(sif.Overflow), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Long frame
    send_frame(16'b1100000001, 10, 1'b0);
    chk("long_par", 32'(sif.ParOut), 32'h01);
    chk("long_bc", 32'(sif.BitCount), 32'd10);
    chk("long_ov", 32'(sif.Overflow), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Saturating length
    send_frame(16'hFFFF, 16, 1'b0);
    chk("sat_bc", 32'(sif.BitCount), 32'd15);
    chk("sat_par", 32'(sif.ParOut), 32'hFF);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // clkEN gating in the middle of a frame
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'(i), 1'(i >> 1), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("gate_par", 32'(sif.ParOut), 32'h05);
    chk("gate_bc", 32'(sif.BitCount), 32'd3);

    // Back-to-back: next frame starts in the DONE cycle
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(16'b101, 3, 1'b0);
    chk("b2b_par", 32'(sif.ParOut), 32'h0D);
    chk("b2b_bc", 32'(sif.BitCount), 32'd4);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-frame reset
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'($urandom), 1'b0);
    cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    chk("mrst_par", 32'(sif.ParOut), 32'd0);
    chk("mrst_fc", 32'(sif.FrameCount), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("mrst_nofd", 32'(sif.FrameDone), 32'd0);
    send_frame(16'h00B2, 8, 1'b1);
    chk("mrst_next_par", 32'(sif.ParOut), 32'hB2);
    chk("mrst_next_fc", 32'(sif.FrameCount), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // 17 frames wrap the counter
    reset2();
    pulses = 0;
    for (int f = 0; f < 17; f++) begin
      len = $urandom_range(1, 14);
      send_frame(16'($urandom), len, 1'b1);
      cycle(1'b0, 1'($urandom), 1'($urandom), 1'b0);
    end
    chk("wrap_pulses", 32'(pulses), 32'd17);
    chk("wrap_fc", 32'(sif.FrameCount), 32'd1);

    // Random traffic
    v_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) v_r = ~v_r;
      cycle(1'($urandom), v_r, 1'($urandom), ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_frame_collector.md
# serial_frame_collector

Downstream consumer of the sequence detector's serial output. Samples the `SerOut`/`SerOutValid` pair on every one-pulsed step enable and assembles each valid burst (frame) into a parallel word. On frame end it publishes the word, the bit length and an overflow flag, and it counts completed frames for the hex display stage.

## Interface
Parameters:
- `WIDTH`, default 8: parallel word width; legal range 2..15.

Ports:
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `clkEN`  input  1  single-cycle step pulse from the one-pulser; the only sampling qualifier.
- `SerOutValid`  input  1  frame-active flag from the sequence detector.
- `SerOut`  input  1  serial data bit from the sequence detector.
- `ParOut`  output  WIDTH  last completed frame word; the last received bit is in the LSB.
- `BitCount`  output  4  number of bits in the last completed frame; saturates at 15.
- `Overflow`  output  1  last completed frame had more than WIDTH bits.
- `FrameDone`  output  1  one-cycle pulse when the output registers update.
- `FrameCount`  output  4  completed frames modulo 16; feeds the hex display.

## Operation
- Sampling: the block acts only in cycles with `clkEN`=1. It uses the `SerOut`/`SerOutValid` values present in that cycle. Cycles with `clkEN`=0 change nothing except the DONE→IDLE exit.
- Internal state: shift register `sh[WIDTH-1:0]`, 4-bit bit counter `cnt`, overflow flag `ov`.
- FSM states are IDLE, COLLECT and DONE. Reset state is IDLE.
  - IDLE, on `clkEN & SerOutValid`: set `sh` = {0…0, `SerOut`}, `cnt`=1, `ov`=0, go to COLLECT.
  - IDLE, otherwise: stay.
  - COLLECT, on `clkEN & SerOutValid`: set `sh` = {`sh[WIDTH-2:0]`, `SerOut`}. Increment `cnt` if it is below 15, otherwise hold at 15. Set `ov`=1 when the bit being added is bit number WIDTH+1 or later.
  - COLLECT, on `clkEN & !SerOutValid`: go to DONE. No bit is shifted.
  - COLLECT, with `clkEN`=0: stay.
  - DONE lasts exactly one cycle. It loads `ParOut`←`sh`, `BitCount`←`cnt` and `Overflow`←`ov`, asserts `FrameDone`, and increments `FrameCount` (wrapping 15→0).
  - DONE exit: if `clkEN & SerOutValid` in the DONE cycle, start a new frame exactly as from IDLE and go to COLLECT. Otherwise go to IDLE.
- Word alignment:
  - Fewer than WIDTH bits: the word is right-aligned and zero-filled above.
  - More than WIDTH bits: only the last WIDTH bits are kept.
- Zero-length frames cannot occur, because a frame always starts with one captured bit.
- `ParOut`, `BitCount`, `Overflow` and `FrameCount` hold their values between DONE cycles.

## Timing
- Reset values (all applied synchronously on `rst`=1 at the clock edge): `ParOut`=0, `BitCount`=0, `Overflow`=0, `FrameDone`=0, `FrameCount`=0, FSM=IDLE, `sh`=0, `cnt`=0, `ov`=0.
- A reset in the middle of a frame discards the partial frame. No `FrameDone` is generated for it.
- `rst` takes priority over every other input.
- Latency: let edge E be the clock edge that ends the `clkEN` cycle seeing `SerOutValid`=0. The FSM is in DONE for the cycle after E. `FrameDone` is high in that cycle, and the new `ParOut`/`BitCount`/`Overflow`/`FrameCount` are visible starting from that same cycle (all registered, updated at E+1? no — registered at E).
- Precise register timing:
  - Outputs are registered at edge E and are visible from the cycle following E.
  - `FrameDone` is high for exactly that one cycle.
  - `FrameDone` is never high in two consecutive cycles.
- All outputs are registered; there is no combinational path from input to output.
- The longest frame is limited only by `cnt` saturation; the FSM never hangs.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs -> all outputs are 0 and the FSM is in IDLE.
- 8-bit frame (WIDTH=8): send bits 1,0,1,1,0,0,1,0 on 8 `clkEN` pulses with valid high, then one pulse with valid low -> one `FrameDone` pulse, `ParOut`=8'hB2, `BitCount`=8, `Overflow`=0, `FrameCount`=1.
- Short frame: send bits 1,1,0 -> `ParOut`=8'h06, `BitCount`=3, `Overflow`=0.
- Long frame: send 10 bits 1,1,0,0,0,0,0,0,0,1 -> `ParOut`=8'h01, `BitCount`=10, `Overflow`=1.
- Clock-enable gating and wrap:
  - Hold `SerOutValid` and `SerOut` toggling with `clkEN`=0 for 20 cycles -> no state change.
  - Complete 17 frames -> `FrameCount`=1, with exactly 17 `FrameDone` pulses.
- Back-to-back frames and mid-frame reset:
  - New frame starting in the DONE cycle -> its first bit is captured and the second frame reports the correct word.
  - Assert `rst` after 4 bits of a frame -> no `FrameDone`, outputs are 0, and the next full frame reports correctly.
